mem_port_arbiter: RTL and testbench

- Shares the single unified memory port between the fetch stage (instruction read) and the memory stage (data load/store).
- Sequences each access over a fixed memory latency.
- Generates the fetch_stall and mem_stall signals that the hazard/forwarding comparator consumes to inject NOPs.
- Data side has priority over fetch, because the older instruction must drain first.

---
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 tb/tb_mem_port_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - unified memory port arbiter, data side over fetch, fixed latency
// Optional stall performance counters built when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter #(
   parameter int LAT    = 4,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_data,
   output logic              fetch_stall,
   input  logic              dm_rd,
   input  logic              dm_wr,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_stall,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [15:0]       if_stall_cnt,
   output logic [15:0]       dm_stall_cnt
);

   typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

   state_t            state, state_nxt;
   logic [3:0]        cnt, cnt_nxt;
   logic              d_wr, d_wr_nxt;
   logic [DATA_W-1:0] if_hold, dm_hold;
   logic              dm_req, i_done, d_done;

   assign dm_req = dm_rd | dm_wr;
   assign i_done = (state == I_BUSY) && (cnt == 4'd0);
   assign d_done = (state == D_BUSY) && (cnt == 4'd0);

   assign fetch_stall = if_req & ~i_done;
   assign mem_stall   = dm_req & ~d_done;

   // Completion data is forwarded in the same cycle; the hold register covers later cycles.
   assign if_data  = i_done ? mem_rdata : if_hold;
   assign dm_rdata = (d_done && !d_wr) ? mem_rdata : dm_hold;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         d_wr    <= 1'b0;
         if_hold <= '0;
         dm_hold <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         d_wr  <= d_wr_nxt;
         if (i_done)
            if_hold <= mem_rdata;
         if (d_done && !d_wr)
            dm_hold <= mem_rdata;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      d_wr_nxt  = d_wr;
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         IDLE: begin
            if (rst_n && dm_req) begin
               mem_en    = 1'b1;
               mem_wr    = dm_wr;
               mem_addr  = dm_addr;
               mem_wdata = dm_wdata;
               state_nxt = D_BUSY;
               cnt_nxt   = 4'(LAT - 1);
               d_wr_nxt  = dm_wr;
            end else if (rst_n && if_req) begin
               mem_en    = 1'b1;
               mem_addr  = if_addr;
               state_nxt = I_BUSY;
               cnt_nxt   = 4'(LAT - 1);
            end
         end
         I_BUSY, D_BUSY: begin
            if (cnt == 4'd0)
               state_nxt = IDLE;
            else
               cnt_nxt = cnt - 4'd1;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef ARB_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_stall_cnt <= 16'h0000;
         dm_stall_cnt <= 16'h0000;
      end else begin
         if (fetch_stall && (if_stall_cnt != 16'hFFFF))
            if_stall_cnt <= if_stall_cnt + 16'd1;
         if (mem_stall && (dm_stall_cnt != 16'hFFFF))
            dm_stall_cnt <= dm_stall_cnt + 16'd1;
      end
   end
`else
   assign if_stall_cnt = 16'h0000;
   assign dm_stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter (LAT=4)
// Honours ARB_PERF_CNT_EN to expect live or tied-off stall counters.
module tb_mem_port_arbiter;

`ifdef ARB_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, dm_rd, dm_wr;
   logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
   logic [15:0] if_data, dm_rdata, mem_addr, mem_wdata;
   logic        fetch_stall, mem_stall, mem_en, mem_wr;
   logic [15:0] if_stall_cnt, dm_stall_cnt;

   mem_port_arbiter #(.LAT(4), .ADDR_W(16), .DATA_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .fetch_stall(fetch_stall),
      .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .mem_stall(mem_stall),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .if_stall_cnt(if_stall_cnt), .dm_stall_cnt(dm_stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        if_req;
      logic [15:0] if_addr;
      logic        dm_rd, dm_wr;
      logic [15:0] dm_addr, dm_wdata, rdata;
      logic        e_en, e_wr;
      logic [15:0] e_addr, e_wdata;
      logic        e_fst, e_mst;
      logic [15:0] e_ifd, e_dmd;
   } vec_t;

   typedef struct {
      logic        wr;
      logic [15:0] addr, wdata;
   } iss_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   iss_t iss_q[$];
   int   checks = 0;
   int   failures = 0;
   int   exp_ifc = 0;
   int   exp_dmc = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic ir, input logic [15:0] ia, input logic rd, input logic wr,
                      input logic [15:0] da, input logic [15:0] dw, input logic [15:0] rdat,
                      input logic een, input logic ewr, input logic [15:0] ea,
                      input logic [15:0] ewd, input logic efs, input logic ems,
                      input logic [15:0] eif, input logic [15:0] edm);
      vec_t v;
      v.if_req = ir;  v.if_addr = ia;   v.dm_rd = rd;   v.dm_wr = wr;
      v.dm_addr = da; v.dm_wdata = dw;  v.rdata = rdat;
      v.e_en = een;   v.e_wr = ewr;     v.e_addr = ea;  v.e_wdata = ewd;
      v.e_fst = efs;  v.e_mst = ems;    v.e_ifd = eif;  v.e_dmd = edm;
      tbl.push_back(v);
   endtask

   task automatic drive_idle();
      if_req = 1'b0; if_addr = 16'h0; dm_rd = 1'b0; dm_wr = 1'b0;
      dm_addr = 16'h0; dm_wdata = 16'h0; mem_rdata = 16'hDEAD;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive_idle();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_ifc = 0;
      exp_dmc = 0;
   endtask

   task automatic run_rows(input int lo, input int hi);
      vec_t v, e;
      iss_t s;
      for (int i = lo; i <= hi; i++) begin
         v = tbl[i];
         @(negedge clk);
         if_req = v.if_req; if_addr = v.if_addr; dm_rd = v.dm_rd; dm_wr = v.dm_wr;
         dm_addr = v.dm_addr; dm_wdata = v.dm_wdata; mem_rdata = v.rdata;
         exp_q.push_back(v);
         if (v.e_en)
            iss_q.push_back('{v.e_wr, v.e_addr, v.e_wdata});
         #1;
         e = exp_q.pop_front();
         chk($sformatf("row%0d mem_en", i), {15'd0, mem_en}, {15'd0, e.e_en});
         chk($sformatf("row%0d fetch_stall", i), {15'd0, fetch_stall}, {15'd0, e.e_fst});
         chk($sformatf("row%0d mem_stall", i), {15'd0, mem_stall}, {15'd0, e.e_mst});
         chk($sformatf("row%0d if_data", i), if_data, e.e_ifd);
         chk($sformatf("row%0d dm_rdata", i), dm_rdata, e.e_dmd);
         chk($sformatf("row%0d if_stall_cnt", i), if_stall_cnt, 16'(exp_ifc));
         chk($sformatf("row%0d dm_stall_cnt", i), dm_stall_cnt, 16'(exp_dmc));
         if (PERF && e.e_fst) exp_ifc++;
         if (PERF && e.e_mst) exp_dmc++;
         if (mem_en) begin
            if (iss_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL row%0d unexpected issue: got addr %h expected none", i, mem_addr);
            end else begin
               s = iss_q.pop_front();
               chk($sformatf("row%0d mem_wr", i), {15'd0, mem_wr}, {15'd0, s.wr});
               chk($sformatf("row%0d mem_addr", i), mem_addr, s.addr);
               if (s.wr)
                  chk($sformatf("row%0d mem_wdata", i), mem_wdata, s.wdata);
            end
         end
      end
   endtask

   initial begin
      // Contended fetch+load, rows 0..10
      add(1,16'h0020,1,0,16'h0200,0,16'hDEAD, 1,0,16'h0200,0, 1,1,16'h0000,16'h0000);
      repeat (3) add(1,16'h0020,1,0,16'h0200,0,16'hDEAD, 0,0,0,0, 1,1,16'h0000,16'h0000);
      add(1,16'h0020,1,0,16'h0200,0,16'h5A5A, 0,0,0,0, 1,0,16'h0000,16'h5A5A);
      add(1,16'h0020,0,0,0,0,16'hDEAD, 1,0,16'h0020,0, 1,0,16'h0000,16'h5A5A);
      repeat (3) add(1,16'h0020,0,0,0,0,16'hDEAD, 0,0,0,0, 1,0,16'h0000,16'h5A5A);
      add(1,16'h0020,0,0,0,0,16'h0F0F, 0,0,0,0, 0,0,16'h0F0F,16'h5A5A);
      add(0,0,0,0,0,0,16'hDEAD, 0,0,0,0, 0,0,16'h0F0F,16'h5A5A);
      // Plain fetch
      add(1,16'h0010,0,0,0,0,16'hDEAD, 1,0,16'h0010,0, 1,0,16'h0F0F,16'h5A5A);
      repeat (3) add(1,16'h0010,0,0,0,0,16'hDEAD, 0,0,0,0, 1,0,16'h0F0F,16'h5A5A);
      add(1,16'h0010,0,0,0,0,16'hA5A5, 0,0,0,0, 0,0,16'hA5A5,16'h5A5A);
      add(0,0,0,0,0,0,16'hDEAD, 0,0,0,0, 0,0,16'hA5A5,16'h5A5A);
      // Store leaves dm_rdata alone
      add(0,0,0,1,16'h0300,16'h1234,16'hDEAD, 1,1,16'h0300,16'h1234, 0,1,16'hA5A5,16'h5A5A);
      repeat (3) add(0,0,0,1,16'h0300,16'h1234,16'hDEAD, 0,0,0,0, 0,1,16'hA5A5,16'h5A5A);
      add(0,0,0,1,16'h0300,16'h1234,16'hBEEF, 0,0,0,0, 0,0,16'hA5A5,16'h5A5A);
      add(0,0,0,0,0,0,16'hDEAD, 0,0,0,0, 0,0,16'hA5A5,16'h5A5A);
      // Fetch squash, then a load waits for the fetch to drain
      add(1,16'h0040,0,0,0,0,16'hDEAD, 1,0,16'h0040,0, 1,0,16'hA5A5,16'h5A5A);
      add(1,16'h0040,0,0,0,0,16'hDEAD, 0,0,0,0, 1,0,16'hA5A5,16'h5A5A);
      add(0,0,0,0,0,0,16'hDEAD, 0,0,0,0, 0,0,16'hA5A5,16'h5A5A);
      add(0,0,1,0,16'h0400,0,16'hDEAD, 0,0,0,0, 0,1,16'hA5A5,16'h5A5A);
      add(0,0,1,0,16'h0400,0,16'h1111, 0,0,0,0, 0,1,16'h1111,16'h5A5A);
      add(0,0,1,0,16'h0400,0,16'hDEAD, 1,0,16'h0400,0, 0,1,16'h1111,16'h5A5A);
      repeat (3) add(0,0,1,0,16'h0400,0,16'hDEAD, 0,0,0,0, 0,1,16'h1111,16'h5A5A);
      add(0,0,1,0,16'h0400,0,16'h2222, 0,0,0,0, 0,0,16'h1111,16'h2222);
      add(0,0,0,0,0,0,16'hDEAD, 0,0,0,0, 0,0,16'h1111,16'h2222);
      // Load and store together behave as a store
      add(0,0,1,1,16'h0500,16'h7777,16'hDEAD, 1,1,16'h0500,16'h7777, 0,1,16'h1111,16'h2222);
      repeat (3) add(0,0,1,1,16'h0500,16'h7777,16'hDEAD, 0,0,0,0, 0,1,16'h1111,16'h2222);
      add(0,0,1,1,16'h0500,16'h7777,16'h3333, 0,0,0,0, 0,0,16'h1111,16'h2222);
      add(0,0,0,0,0,0,16'hDEAD, 0,0,0,0, 0,0,16'h1111,16'h2222);

      // Reset state with requests asserted
      rst_n = 1'b0;
      drive_idle();
      if_req = 1'b1;
      dm_rd = 1'b1;
      dm_addr = 16'h0123;
      #12;
      chk("rst mem_en", {15'd0, mem_en}, 16'd0);
      chk("rst mem_addr", mem_addr, 16'h0000);
      chk("rst fetch_stall", {15'd0, fetch_stall}, 16'd1);
      chk("rst mem_stall", {15'd0, mem_stall}, 16'd1);
      chk("rst if_data", if_data, 16'h0000);
      chk("rst dm_rdata", dm_rdata, 16'h0000);
      repeat (2) @(negedge clk);
      chk("rst if_stall_cnt", if_stall_cnt, 16'h0000);
      chk("rst dm_stall_cnt", dm_stall_cnt, 16'h0000);
      drive_idle();
      rst_n = 1'b1;

      run_rows(0, 10);
      chk("contended if_stall_cnt", if_stall_cnt, PERF ? 16'd9 : 16'd0);
      chk("contended dm_stall_cnt", dm_stall_cnt, PERF ? 16'd4 : 16'd0);
      run_rows(11, tbl.size() - 1);

      // Reset pulse during D_BUSY at cnt=2, load re-issued right after release
      @(negedge clk);
      dm_rd = 1'b1;
      dm_addr = 16'h0600;
      #1;
      chk("rb issue mem_en", {15'd0, mem_en}, 16'd1);
      chk("rb issue mem_addr", mem_addr, 16'h0600);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rb in-reset mem_en", {15'd0, mem_en}, 16'd0);
      chk("rb in-reset mem_stall", {15'd0, mem_stall}, 16'd1);
      chk("rb in-reset dm_rdata", dm_rdata, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rb reissue mem_en", {15'd0, mem_en}, 16'd1);
      chk("rb reissue mem_wr", {15'd0, mem_wr}, 16'd0);
      chk("rb reissue mem_addr", mem_addr, 16'h0600);
      repeat (3) @(negedge clk);
      #1;
      chk("rb busy mem_stall", {15'd0, mem_stall}, 16'd1);
      @(negedge clk);
      mem_rdata = 16'h4444;
      #1;
      chk("rb done mem_stall", {15'd0, mem_stall}, 16'd0);
      chk("rb done dm_rdata", dm_rdata, 16'h4444);
      @(negedge clk);
      drive_idle();
      #1;
      chk("rb hold dm_rdata", dm_rdata, 16'h4444);

      // Data side hogging the port starves fetch long enough to saturate
      do_reset();
      @(negedge clk);
      if_req = 1'b1;
      dm_rd = 1'b1;
      dm_addr = 16'h0700;
      repeat (70000) @(negedge clk);
      #1;
      chk("sat fetch_stall", {15'd0, fetch_stall}, 16'd1);
      chk("sat if_stall_cnt", if_stall_cnt, PERF ? 16'hFFFF : 16'h0000);
      drive_idle();

      chk("issue queue drained", 16'(iss_q.size()), 16'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
